clock_switch_ctrl: RTL and testbench

Sequencer that owns the 5-bit clock-select register feeding the crypto clock mux and target clock output. It applies a new configuration without glitching the target clock. The sequence is: hold target reset, turn the target clock output off, confirm the new source is alive, switch the source, settle, re-enable the output, then release reset. Runs in the usb_clk domain between the register interface and the clock mux.

---
 rtl/clock_switch_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_clock_switch_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_switch_ctrl.sv
// Glitch-free sequencer for the crypto clock-select register: quiesce the target,
// confirm the new source is alive, switch with the output off, settle, then release.
module clock_switch_ctrl #(
  parameter int QUIESCE_CYC  = 16,
  parameter int SETTLE_CYC   = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int ACT_WINDOW   = 256,
  parameter int ACT_MIN      = 8
) (
  input  logic       usb_clk,
  input  logic       rst_n,
  input  logic       cfg_wr,
  input  logic [4:0] cfg_data,
  input  logic       j16_sel,
  input  logic       pll_locked,
  input  logic       cw_clkin_smp,
  input  logic       err_clr,
  output logic [4:0] clock_reg_o,
  output logic       target_rst_n,
  output logic       busy,
  output logic       ext_alive,
  output logic [1:0] err_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] QUIESCE = 3'd1;
  localparam logic [2:0] CHECK   = 3'd2;
  localparam logic [2:0] SWITCH  = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  localparam int CNT_MAX = (LOCK_TIMEOUT > SETTLE_CYC) ?
                           ((LOCK_TIMEOUT > QUIESCE_CYC) ? LOCK_TIMEOUT : QUIESCE_CYC) :
                           ((SETTLE_CYC > QUIESCE_CYC) ? SETTLE_CYC : QUIESCE_CYC);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int WIN_W = $clog2(ACT_WINDOW);
  localparam int ACT_W = $clog2(ACT_WINDOW + 1);

  function automatic logic src_ext(input logic [4:0] c, input logic j);
    return (c[2:0] == 3'b101) | (~c[0] & j);
  endfunction

  function automatic logic [4:0] force_cfg(input logic [4:0] c, input logic j);
    return src_ext(c, j) ? 5'b00101 : 5'b00001;
  endfunction

  logic             pll_meta, pll_sync;
  logic             j16_meta, j16_sync;
  logic             smp_meta, smp_sync, smp_prev;
  logic [WIN_W-1:0] win_cnt;
  logic [ACT_W-1:0] act_cnt, act_inc;
  logic             smp_rise;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [4:0]       target, cur_cfg, pend_cfg, sw_cfg, req_cfg;
  logic             pend_vld, j16_used;
  logic             tgt_ext, cond_ok, timed_out, req_new;
  logic [1:0]       err_set;

  // Synchronisers run through reset so they already track their inputs at reset exit.
  always_ff @(posedge usb_clk) begin
    pll_meta <= pll_locked;
    pll_sync <= pll_meta;
    j16_meta <= j16_sel;
    j16_sync <= j16_meta;
    smp_meta <= cw_clkin_smp;
    smp_sync <= smp_meta;
    smp_prev <= smp_sync;
  end

  assign smp_rise = smp_sync & ~smp_prev;
  assign act_inc  = (act_cnt == ACT_W'(ACT_WINDOW)) ? act_cnt : act_cnt + ACT_W'(smp_rise);

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      act_cnt   <= '0;
      ext_alive <= 1'b0;
    end else if (win_cnt == WIN_W'(ACT_WINDOW - 1)) begin
      win_cnt   <= '0;
      act_cnt   <= '0;
      ext_alive <= (act_inc >= ACT_W'(ACT_MIN));
    end else begin
      win_cnt <= win_cnt + WIN_W'(1);
      act_cnt <= act_inc;
    end
  end

  always_comb begin
    tgt_ext   = src_ext(target, j16_sync);
    cond_ok   = tgt_ext ? ext_alive : pll_sync;
    timed_out = (cnt == CNT_W'(LOCK_TIMEOUT - 1));
    cnt_inc   = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + CNT_W'(1);
    err_set   = 2'b00;
    sw_cfg    = target;
    if (state == CHECK && !cond_ok && timed_out) begin
      err_set = tgt_ext ? 2'b10 : 2'b01;
      // A dead external clock falls back to the safe default source.
      if (tgt_ext) sw_cfg = 5'b00001;
    end
    req_new = cfg_wr | pend_vld;
    req_cfg = cfg_wr ? cfg_data : pend_cfg;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CHECK;
      cnt          <= '0;
      target       <= 5'b00001;
      cur_cfg      <= 5'b00001;
      pend_cfg     <= 5'b00000;
      pend_vld     <= 1'b0;
      j16_used     <= 1'b0;
      clock_reg_o  <= 5'b00001;
      target_rst_n <= 1'b0;
      err_o        <= 2'b00;
    end else begin
      err_o <= (err_clr ? 2'b00 : err_o) | err_set;
      if (cfg_wr && (state == QUIESCE || state == CHECK || state == SWITCH)) begin
        pend_vld <= 1'b1;
        pend_cfg <= cfg_data;
      end
      case (state)
        IDLE: begin
          // DIP changes in DIP mode are re-sequenced rather than applied live.
          if (cfg_wr || (!cur_cfg[0] && (j16_sync != j16_used))) begin
            target       <= cfg_wr ? cfg_data : cur_cfg;
            state        <= QUIESCE;
            cnt          <= '0;
            clock_reg_o  <= force_cfg(cur_cfg, j16_used);
            target_rst_n <= 1'b0;
          end
        end
        QUIESCE: begin
          if (cnt == CNT_W'(QUIESCE_CYC - 1)) begin
            state <= CHECK;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        CHECK: begin
          if (cond_ok || timed_out) begin
            state       <= SWITCH;
            cnt         <= '0;
            target      <= sw_cfg;
            clock_reg_o <= force_cfg(sw_cfg, j16_sync);
            j16_used    <= j16_sync;
          end else begin
            cnt <= cnt_inc;
          end
        end
        SWITCH: begin
          if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
            state       <= RELEASE;
            cnt         <= '0;
            clock_reg_o <= target;
            cur_cfg     <= target;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RELEASE: begin
          if (req_new) begin
            target       <= req_cfg;
            pend_vld     <= 1'b0;
            state        <= QUIESCE;
            cnt          <= '0;
            clock_reg_o  <= force_cfg(cur_cfg, j16_used);
            target_rst_n <= 1'b0;
          end else begin
            state        <= IDLE;
            target_rst_n <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Randomised bench for clock_switch_ctrl against a timeline model of each switch sequence.
module tb_clock_switch_ctrl;

  localparam int Q  = 16;
  localparam int S  = 64;
  localparam int LT = 4096;

  logic       usb_clk, rst_n, cfg_wr, j16_sel, pll_locked, cw_clkin_smp, err_clr;
  logic [4:0] cfg_data, clock_reg_o;
  logic       target_rst_n, busy, ext_alive;
  logic [1:0] err_o;

  clock_switch_ctrl dut (
    .usb_clk(usb_clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_data(cfg_data),
    .j16_sel(j16_sel), .pll_locked(pll_locked), .cw_clkin_smp(cw_clkin_smp),
    .err_clr(err_clr), .clock_reg_o(clock_reg_o), .target_rst_n(target_rst_n),
    .busy(busy), .ext_alive(ext_alive), .err_o(err_o)
  );

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    bit         is_pll;
    logic [4:0] data;
  } inj_t;
  inj_t inj_q[$];

  logic [4:0] m_cur;
  logic       m_japp;
  bit         ext_run;
  int         ext_half;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ext(input logic [4:0] c, input logic j);
    return (c[2:0] == 3'b101) || (!c[0] && j);
  endfunction

  function automatic logic [4:0] m_force(input logic [4:0] c, input logic j);
    return m_ext(c, j) ? 5'b00101 : 5'b00001;
  endfunction

  task automatic step();
    @(negedge usb_clk);
  endtask

  task automatic write_cfg(input logic [4:0] c);
    cfg_data = c;
    cfg_wr   = 1'b1;
    step();
  endtask

  // Entered at cycle 1 of a sequence; follows it to the cycle after RELEASE.
  task automatic watch(input string tag, input int qlen, input int clen, input logic [4:0] fin,
                       input logic [1:0] exp_err, input bit chained);
    int pre, rel, pre_bad, sw_bad;
    logic [4:0] f_from, f_fin;
    pre     = qlen + clen;
    rel     = pre + S + 1;
    f_from  = m_force(m_cur, m_japp);
    f_fin   = m_force(fin, j16_sel);
    pre_bad = 0;
    sw_bad  = 0;
    for (int k = 1; k <= rel + 1; k++) begin
      if (k > 1) step();
      cfg_wr = 1'b0;
      if (k <= pre) begin
        if (clock_reg_o !== f_from || target_rst_n !== 1'b0 || busy !== 1'b1) pre_bad++;
      end else if (k <= pre + S) begin
        if (clock_reg_o !== f_fin || target_rst_n !== 1'b0 || busy !== 1'b1) sw_bad++;
      end else if (k == rel) begin
        chk({tag, ".rel_clk"}, clock_reg_o, fin);
        chk({tag, ".rel_rst"}, target_rst_n, 1'b0);
      end else begin
        chk({tag, ".rst_after"}, target_rst_n, !chained);
        chk({tag, ".busy_after"}, busy, chained);
        chk({tag, ".err"}, err_o, exp_err);
      end
      while (inj_q.size() > 0 && inj_q[0].cyc == k) begin
        if (inj_q[0].is_pll) pll_locked = 1'b1;
        else begin
          cfg_data = inj_q[0].data;
          cfg_wr   = 1'b1;
        end
        void'(inj_q.pop_front());
      end
    end
    chk({tag, ".pre_phase_bad"}, pre_bad, 0);
    chk({tag, ".switch_phase_bad"}, sw_bad, 0);
    m_cur  = fin;
    m_japp = j16_sel;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".clk"}, clock_reg_o, 5'b00001);
    chk({tag, ".trst"}, target_rst_n, 1'b0);
    chk({tag, ".busy"}, busy, 1'b1);
    chk({tag, ".alive"}, ext_alive, 1'b0);
    chk({tag, ".err"}, err_o, 2'b00);
  endtask

  // External clock stimulus: square wave with half-period ext_half while ext_run.
  initial begin
    int ph;
    ph = 0;
    cw_clkin_smp = 1'b0;
    forever begin
      @(negedge usb_clk);
      if (ext_run) begin
        ph++;
        if (ph >= ext_half) begin
          ph = 0;
          cw_clkin_smp = ~cw_clkin_smp;
        end
      end else begin
        cw_clkin_smp = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] c;
    int p;
    ext_run    = 1'b1;
    ext_half   = 4;
    rst_n      = 1'b0;
    cfg_wr     = 1'b0;
    cfg_data   = 5'b0;
    j16_sel    = 1'b0;
    pll_locked = 1'b1;
    err_clr    = 1'b0;
    m_cur      = 5'b00001;
    m_japp     = 1'b0;
    repeat (5) step();
    chk_reset_vals("reset");

    // Power-up sequence starts in CHECK
    rst_n = 1'b1;
    watch("pwr", 0, 1, 5'b00001, 2'b00, 1'b0);
    repeat (300) step();
    chk("alive_on", ext_alive, 1'b1);

    write_cfg(5'b01101);
    watch("ext", Q, 1, 5'b01101, 2'b00, 1'b0);

    ext_half = $urandom_range(2, 6);
    for (int i = 0; i < 4; i++) begin
      c = 5'($urandom);
      repeat ($urandom_range(1, 5)) step();
      write_cfg(c);
      watch("rnd", Q, 1, c, 2'b00, 1'b0);
    end

    pll_locked = 1'b0;
    repeat (4) step();
    p = $urandom_range(20, 600);
    inj_q.push_back('{cyc: p, is_pll: 1'b1, data: 5'b0});
    write_cfg(5'b00001);
    watch("pll", Q, p + 2 - Q, 5'b00001, 2'b00, 1'b0);

    inj_q.push_back('{cyc: 3, is_pll: 1'b0, data: 5'b00001});
    inj_q.push_back('{cyc: 9, is_pll: 1'b0, data: 5'b01101});
    step();
    write_cfg(5'b00101);
    watch("pend1", Q, 1, 5'b00101, 2'b00, 1'b1);
    watch("pend2", Q, 1, 5'b01101, 2'b00, 1'b0);

    ext_run = 1'b0;
    repeat (600) step();
    chk("alive_off", ext_alive, 1'b0);
    write_cfg(5'b01101);
    watch("tmo", Q, LT, 5'b00001, 2'b10, 1'b0);
    repeat (5) step();
    chk("err_sticky", err_o, 2'b10);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr", err_o, 2'b00);
    ext_run = 1'b1;
    repeat (600) step();
    chk("alive_back", ext_alive, 1'b1);

    write_cfg(5'b10000);
    watch("dip_set", Q, 1, 5'b10000, 2'b00, 1'b0);
    repeat (3) step();
    j16_sel = 1'b1;
    step();
    step();
    chk("dip_idle", busy, 1'b0);
    step();
    watch("dip_tog", Q, 1, 5'b10000, 2'b00, 1'b0);
    repeat (3) step();
    j16_sel = 1'b0;
    repeat (3) step();
    watch("dip_back", Q, 1, 5'b10000, 2'b00, 1'b0);

    step();
    write_cfg(5'b01101);
    cfg_wr = 1'b0;
    repeat (39) step();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    repeat (3) step();
    rst_n  = 1'b1;
    m_cur  = 5'b00001;
    m_japp = 1'b0;
    watch("pwr2", 0, 1, 5'b00001, 2'b00, 1'b0);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
